mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001: Parameter MAX_BURST, default 8, maximum consecutive beats one owner holds the port while the other requester waits.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: nrst  input  1  asynchronous, active-low reset.
REQ-004: req0 / req1  input  1  requester 0/1 wants the memory port; held high for the whole transfer.
REQ-005: wr0 / wr1  input  1  1 = write beat, 0 = read beat.
REQ-006: addr0 / addr1  input  32  byte address of the beat.
REQ-007: wdata0 / wdata1  input  32  write data.
REQ-008: gnt0 / gnt1  output  1  registered grant; at most one high in any cycle.
REQ-009: rvalid0 / rvalid1  output  1  read data valid for requester 0/1.
REQ-010: rdata0 / rdata1  output  32  read data; both equal mem_rdata.
REQ-011: mem_addr  output  32  word-aligned address to memory.
REQ-012: mem_wr_en  output  1  memory write strobe.
REQ-013: mem_wdata  output  32  memory write data.
REQ-014: mem_rdata  input  32  memory read data, valid one cycle after the read address is presented.
REQ-015: owner  output  1  index of current or last grantee.
REQ-016: busy  output  1  high when either gnt is high.

Function
REQ-017: States IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1), both registered.
REQ-018: Beat = cycle where gntN and reqN are both high; non-owner request ignored for memory access.
REQ-019: During a beat: mem_addr = {addrN[31:2],2'b00}, mem_wdata = wdataN, mem_wr_en = wrN, all combinational from the owner's inputs.
REQ-020: No beat: mem_addr = 0, mem_wdata = 0, mem_wr_en = 0.
REQ-021: Read beat at cycle t: rvalidN high at cycle t+1 only, rdataN = mem_rdata at t+1.
REQ-022: Pending rvalid still delivered to the requester that issued the read, even if ownership changed at t+1.
REQ-023: IDLE: req from one requester only -> OWN that requester next edge; neither -> stay IDLE.
REQ-024: IDLE, both requesting -> grant requester not equal to last-served pointer lsp; lsp reset value 1, so requester 0 wins first.
REQ-025: OWNn, reqN low -> OWNm next edge if reqM high (zero idle cycles), else IDLE.
REQ-026: Beat counter (width ceil(log2(MAX_BURST+1))) clears on entering OWNx; increments each beat.
REQ-027: Beat that brings count to MAX_BURST with reqM high: beat executes, then OWNm next edge.
REQ-028: Count reaches MAX_BURST with reqM low: count clears, ownership retained.
REQ-029: lsp and owner updated to N on every entry to OWNn; owner holds value in IDLE.
REQ-030: Requester dropping req while gnt high: that cycle is not a beat, no memory access.
REQ-031: addrN[1:0] ignored; no misalignment error.

Reset
REQ-032: nrst low asynchronously forces state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, count=0, lsp=1, owner=0, busy=0.
REQ-033: Asserting nrst mid-burst drops mem_wr_en to 0 in the same cycle; pending read data is discarded, with no rvalid after reset release.
REQ-034: First grant possible on the first rising edge after nrst deasserts.

Verification
REQ-035: req0=1 only, wr0=1, addr0=0x4, 0x8, 0xC, wdata0=0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003 -> gnt0 high one cycle after req0; three mem_wr_en pulses with mem_addr 0x4, 0x8, 0xC and matching data.
REQ-036: req0 and req1 both rise in the same cycle from reset -> gnt0 first; after req0 drops, gnt1 the next cycle with no IDLE gap.
REQ-037: req0 held 20 beats, req1 high throughout, MAX_BURST=8 -> gnt0 for 8 beats, gnt1 for 8 beats, then gnt0; never both high.
REQ-038: Read beat addr1=0x13 with mem model returning 0xDEAD_BEEF -> mem_addr=0x10; rvalid1 high one cycle later with rdata1=0xDEAD_BEEF; rvalid0 stays 0.
REQ-039: Last beat of OWN0 is a read and req1 is high -> rvalid0 and gnt1 are both high in the next cycle.
REQ-040: nrst pulsed low mid-write-burst -> mem_wr_en, gnt0, gnt1, busy, rvalid* go 0 immediately; after release with req1 high, gnt1 on the first edge.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory. One requester owns the
// port at a time; ownership alternates on request drop or after MAX_BURST
// consecutive beats while the other side is waiting.
module mem_port_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        owner,
    output logic        busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          lsp;
    logic          lsp_next;
    logic          owner_next;
    logic          beat0;
    logic          beat1;
    logic          last_beat;
    logic          unused_addr_bits;

    assign gnt0  = (state == OWN0);
    assign gnt1  = (state == OWN1);
    assign busy  = gnt0 | gnt1;
    assign beat0 = gnt0 & req0;
    assign beat1 = gnt1 & req1;

    // The beat that brings the count up to MAX_BURST ends the burst window.
    assign last_beat = (count == CW'(MAX_BURST - 1));

    // Memory side is driven straight from the owner's inputs during a beat.
    assign mem_addr  = beat0 ? {addr0[31:2], 2'b00} :
                       beat1 ? {addr1[31:2], 2'b00} : 32'd0;
    assign mem_wdata = beat0 ? wdata0 : beat1 ? wdata1 : 32'd0;
    assign mem_wr_en = (beat0 & wr0) | (beat1 & wr1);

    assign rdata0 = mem_rdata;
    assign rdata1 = mem_rdata;

    // Byte offset bits are dropped on purpose; accesses are always word-wide.
    assign unused_addr_bits = ^{addr0[1:0], addr1[1:0]};

    // State, beat counter, fairness pointer and owner registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            count <= '0;
            lsp   <= 1'b1;
            owner <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            lsp   <= lsp_next;
            owner <= owner_next;
        end
    end

    // Read-valid pipeline: a read beat returns data one cycle later to its issuer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= beat0 & ~wr0;
            rvalid1 <= beat1 & ~wr1;
        end
    end

    // Next-state: arbitration, burst limiting and hand-over bookkeeping.
    always_comb begin
        state_next = state;
        count_next = count;
        lsp_next   = lsp;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_next = lsp ? OWN0 : OWN1;
                end else if (req0) begin
                    state_next = OWN0;
                end else if (req1) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_next = req1 ? OWN1 : IDLE;
                end else if (last_beat) begin
                    count_next = '0;
                    if (req1) begin
                        state_next = OWN1;
                    end
                end else begin
                    count_next = count + CW'(1);
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_next = req0 ? OWN0 : IDLE;
                end else if (last_beat) begin
                    count_next = '0;
                    if (req0) begin
                        state_next = OWN0;
                    end
                end else begin
                    count_next = count + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Any change of state starts a fresh burst; entering OWNn records n.
        if (state_next != state) begin
            count_next = '0;
            if (state_next == OWN0) begin
                lsp_next   = 1'b0;
                owner_next = 1'b0;
            end else if (state_next == OWN1) begin
                lsp_next   = 1'b1;
                owner_next = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences
// and randomized traffic against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr_en, owner, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk(clk), .nrst(nrst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 + 32'(i));
    endfunction

    // Memory stub: one-cycle read latency, contents restored during reset.
    logic [31:0] smem [64];
    always @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < 64; i++) smem[i] <= init_word(i);
            mem_rdata <= 32'd0;
        end else begin
            if (mem_wr_en) smem[mem_addr[7:2]] <= mem_wdata;
            mem_rdata <= smem[mem_addr[7:2]];
        end
    end

    // Behavioural model: owner index (-1 idle), beats used in current window,
    // last-served requester, pending read per requester, memory image.
    int          m_own, m_used, m_last, m_owner;
    logic        m_pv [2];
    logic [31:0] m_pd [2];
    logic [31:0] m_mem [64];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_used = 0; m_last = 1; m_owner = 0;
        m_pv[0] = 0; m_pv[1] = 0; m_pd[0] = 0; m_pd[1] = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
    endtask

    function automatic logic cur_req(int i);
        return (i == 0) ? req0 : req1;
    endfunction

    task automatic model_check();
        logic beat;
        logic [31:0] ea, ed;
        logic ew;
        beat = (m_own >= 0) && cur_req(m_own);
        ea = 0; ed = 0; ew = 0;
        if (beat) begin
            ea = ((m_own == 0) ? addr0 : addr1) & 32'hFFFF_FFFC;
            ed = (m_own == 0) ? wdata0 : wdata1;
            ew = (m_own == 0) ? wr0 : wr1;
        end
        chk("m_gnt0", 32'(gnt0), 32'(m_own == 0));
        chk("m_gnt1", 32'(gnt1), 32'(m_own == 1));
        chk("m_busy", 32'(busy), 32'(m_own >= 0));
        chk("m_owner", 32'(owner), 32'(m_owner));
        chk("m_mem_addr", mem_addr, ea);
        chk("m_mem_wdata", mem_wdata, ed);
        chk("m_mem_wr_en", 32'(mem_wr_en), 32'(ew));
        chk("m_rvalid0", 32'(rvalid0), 32'(m_pv[0]));
        chk("m_rvalid1", 32'(rvalid1), 32'(m_pv[1]));
        if (m_pv[0]) chk("m_rdata0", rdata0, m_pd[0]);
        if (m_pv[1]) chk("m_rdata1", rdata1, m_pd[1]);
    endtask

    task automatic model_advance();
        int o, x, nxt, idx;
        logic beat, w, ro, rx;
        o = m_own;
        x = 1 - o;
        beat = (o >= 0) && cur_req(o);
        m_pv[0] = 0; m_pv[1] = 0;
        if (beat) begin
            w   = (o == 0) ? wr0 : wr1;
            idx = int'(((o == 0) ? addr0[7:2] : addr1[7:2]));
            if (w) m_mem[idx] = (o == 0) ? wdata0 : wdata1;
            else begin
                m_pv[o] = 1;
                m_pd[o] = m_mem[idx];
            end
        end
        if (o < 0) begin
            if (req0 && req1) nxt = 1 - m_last;
            else if (req0)    nxt = 0;
            else if (req1)    nxt = 1;
            else              nxt = -1;
        end else begin
            ro = cur_req(o);
            rx = cur_req(x);
            if (!ro) nxt = rx ? x : -1;
            else begin
                m_used++;
                nxt = o;
                if (m_used == MAXB) begin
                    m_used = 0;
                    if (rx) nxt = x;
                end
            end
        end
        if (nxt != o) begin
            m_used = 0;
            if (nxt >= 0) begin
                m_last  = nxt;
                m_owner = nxt;
            end
        end
        m_own = nxt;
    endtask

    task automatic drive(logic r0, logic r1, logic w0, logic w1,
                         logic [31:0] a0, logic [31:0] a1,
                         logic [31:0] d0, logic [31:0] d1);
        req0 = r0; req1 = r1; wr0 = w0; wr1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0;
        logic        g0, g1, we;
        logic [31:0] ma, md;
        logic        rv0, rv1;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(logic r0, logic r1, logic w0, logic w1,
                                logic [31:0] a0, logic [31:0] a1, logic [31:0] d0,
                                logic g0, logic g1, logic we,
                                logic [31:0] ma, logic [31:0] md,
                                logic rv0, logic rv1, logic [31:0] rd);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0;
        v.g0 = g0; v.g1 = g1; v.we = we; v.ma = ma; v.md = md;
        v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
        return v;
    endfunction

    vec_t tbl [15];
    int   seq [32];

    initial begin
        // Inputs r0 r1 w0 w1 a0 a1 d0 | expected g0 g1 we ma md rv0 rv1 rd
        tbl[0]  = mk(1, 0, 1, 0, 32'h4,  0, 32'hA5A5_0001, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 32'h4,  0, 32'hA5A5_0001, 1, 0, 1, 32'h4, 32'hA5A5_0001, 0, 0, 0);
        tbl[2]  = mk(1, 0, 1, 0, 32'h8,  0, 32'hA5A5_0002, 1, 0, 1, 32'h8, 32'hA5A5_0002, 0, 0, 0);
        tbl[3]  = mk(1, 0, 1, 0, 32'hC,  0, 32'hA5A5_0003, 1, 0, 1, 32'hC, 32'hA5A5_0003, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0, 32'h13, 0, 0, 1, 0, 32'h10, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 32'h20, 32'h24, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 1, 0, 0, 32'h20, 32'h24, 0, 1, 0, 0, 32'h20, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 32'h20, 32'h24, 0, 1, 0, 0, 0, 0, 1, 0, 32'hC0DE_0008);
        tbl[12] = mk(0, 1, 0, 0, 0, 32'h24, 0, 0, 1, 0, 32'h24, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hC0DE_0009);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        nrst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        settle();
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 0);
        nrst = 1'b1;
        advance();

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1,
                  tbl[i].a0, tbl[i].a1, tbl[i].d0, 32'd0);
            settle();
            chk($sformatf("tbl%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
            chk($sformatf("tbl%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
            chk($sformatf("tbl%0d_wr_en", i), 32'(mem_wr_en), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].ma);
            chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].md);
            chk($sformatf("tbl%0d_rvalid0", i), 32'(rvalid0), 32'(tbl[i].rv0));
            chk($sformatf("tbl%0d_rvalid1", i), 32'(rvalid1), 32'(tbl[i].rv1));
            if (tbl[i].rv0) chk($sformatf("tbl%0d_rdata0", i), rdata0, tbl[i].rd);
            if (tbl[i].rv1) chk($sformatf("tbl%0d_rdata1", i), rdata1, tbl[i].rd);
            $display("vec %0d: gnt=%b%b we=%b addr=%h rv=%b%b", i, gnt1, gnt0,
                     mem_wr_en, mem_addr, rvalid1, rvalid0);
            advance();
        end

        // Simultaneous requests out of reset: 0 first, then 1 with no gap
        do_reset();
        drive(1, 1, 1, 1, 32'h40, 32'h44, 32'h11, 32'h22);
        settle();
        advance();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("both_first_gnt0", 32'({gnt1, gnt0}), 32'b01);
            advance();
        end
        req0 = 1'b0;
        settle();
        advance();
        settle();
        chk("handover_gnt1", 32'({gnt1, gnt0}), 32'b10);
        $display("seq handover: gnt=%b%b", gnt1, gnt0);
        advance();

        // Burst limit with both requesting; requester 0 reads, 1 writes
        do_reset();
        for (int c = 0; c < 32; c++) begin
            drive(1, 1, 0, 1, $urandom, $urandom, $urandom, $urandom);
            settle();
            seq[c] = gnt0 ? 1 : (gnt1 ? 2 : 0);
            chk("exclusive_gnt", 32'(gnt0 & gnt1), 0);
            if (c == 9) begin
                chk("last_read_rvalid0", 32'(rvalid0), 1);
                chk("last_read_gnt1", 32'(gnt1), 1);
            end
            advance();
        end
        begin
            int n0, n1;
            n0 = 0; n1 = 0;
            for (int c = 1; c <= 8; c++) if (seq[c] == 1) n0++;
            for (int c = 9; c <= 16; c++) if (seq[c] == 2) n1++;
            chk("burst0_len", 32'(n0), 8);
            chk("burst1_len", 32'(n1), 8);
            chk("burst_back_to0", 32'(seq[17]), 1);
            chk("burst_back_to1", 32'(seq[25]), 2);
            $display("seq burst: run0=%0d run1=%0d next=%0d", n0, n1, seq[17]);
        end

        // Window expiry with no contender keeps ownership
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive(1, 0, 1, 0, 32'(c * 4), 0, $urandom, 0);
            settle();
            advance();
        end
        settle();
        chk("solo_retain_gnt0", 32'(gnt0), 1);
        $display("seq solo: gnt0=%b after 13 beats", gnt0);

        // Asynchronous reset in the middle of a burst with a read pending
        do_reset();
        drive(1, 0, 0, 0, 32'h8, 0, 0, 0);
        settle();
        advance();
        settle();
        advance();
        drive(1, 0, 1, 0, 32'hC, 0, 32'h5555_AAAA, 0);
        settle();
        nrst = 1'b0;
        #1;
        chk("arst_wr_en", 32'(mem_wr_en), 0);
        chk("arst_gnt", 32'({gnt1, gnt0}), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rvalid", 32'({rvalid1, rvalid0}), 0);
        model_reset();
        drive(0, 1, 0, 0, 0, 32'h30, 0, 0);
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        settle();
        advance();
        settle();
        chk("arst_release_gnt1", 32'(gnt1), 1);
        $display("seq async reset: gnt1=%b rv=%b%b", gnt1, rvalid1, rvalid0);
        advance();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 9) < 7) ? req0 : ~req0,
                  ($urandom_range(0, 9) < 7) ? req1 : ~req1,
                  1'($urandom), 1'($urandom),
                  $urandom, $urandom, $urandom, $urandom);
            settle();
            advance();
        end
        $display("random traffic: 3000 cycles applied");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
